// File: rtl/pico_rst_pkg.sv
// Shared definitions for the pico tile reset sequencer.
// - rst_state_e      : sequencer state (idle, hold all targets low, staggered release)
// - DefHoldCycles    : default cycles targets stay in reset before the first release
// - DefStaggerCycles : default cycles between consecutive unit releases
package pico_rst_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRelease
  } rst_state_e;

  localparam int unsigned DefHoldCycles    = 16;
  localparam int unsigned DefStaggerCycles = 4;

endpackage

// File: rtl/pico_rst_pick.sv
// Lowest-set-bit selector used to choose the next unit to release.
// Ports:
//   req_i    : candidate bits
//   onehot_o : one-hot of the lowest set bit of req_i (all zero if none)
//   any_o    : at least one bit of req_i is set
module pico_rst_pick #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] onehot_o,
  output logic             any_o
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    onehot_o = req_i & (~req_i + Width'(1));
    any_o    = |req_i;
  end

endmodule

// File: rtl/pico_reset_seq.sv
// Reset sequencer for the pico tile cluster. Holds targeted units in reset, then releases
// them one at a time in ascending index order. Runs a full sequence after rst and on each
// accepted soft-reset request.
// Ports:
//   gclk       : clock
//   rst        : synchronous active-high reset; aborts any sequence and restarts POR
//   sreq_val   : soft-reset request valid
//   sreq_mask  : units to reset, bit i = unit i
//   sreq_rdy   : request can be accepted (registered)
//   done       : one-cycle pulse when the last targeted unit is released (registered)
//   busy       : sequence in progress (registered)
//   unit_rst_l : per-unit active-low reset (registered)
module pico_reset_seq
  import pico_rst_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned HOLD_CYCLES    = DefHoldCycles,
  parameter int unsigned STAGGER_CYCLES = DefStaggerCycles
) (
  input  logic                 gclk,
  input  logic                 rst,
  input  logic                 sreq_val,
  input  logic [NUM_UNITS-1:0] sreq_mask,
  output logic                 sreq_rdy,
  output logic                 done,
  output logic                 busy,
  output logic [NUM_UNITS-1:0] unit_rst_l
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLoad    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLoad = CntW'(STAGGER_CYCLES - 1);

  rst_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] rem_q, rem_d;
  logic [NUM_UNITS-1:0] unit_rst_l_q, unit_rst_l_d;
  logic                 done_q, done_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic [NUM_UNITS-1:0] pick_oh;
  logic                 pick_any;
  logic                 do_release;

  pico_rst_pick #(
    .Width (NUM_UNITS)
  ) u_pick (
    .req_i    (rem_q),
    .onehot_o (pick_oh),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    unit_rst_l_d = unit_rst_l_q;
    done_d       = 1'b0;
    do_release   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sreq_val && rdy_q) begin
          rem_d = sreq_mask;
          if (|sreq_mask) begin
            state_d      = StHold;
            cnt_d        = HoldLoad;
            unit_rst_l_d = unit_rst_l_q & ~sreq_mask;
          end else begin
            // Empty request completes immediately; the release state with an empty
            // remaining mask provides the single non-ready done cycle.
            state_d = StRelease;
            done_d  = 1'b1;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          do_release = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRelease: begin
        if (!pick_any) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          do_release = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StHold;
    endcase

    if (do_release) begin
      unit_rst_l_d = unit_rst_l_q | pick_oh;
      rem_d        = rem_q & ~pick_oh;
      cnt_d        = StaggerLoad;
      state_d      = StRelease;
      done_d       = (rem_q == pick_oh);
    end

    rdy_d  = (state_d == StIdle);
    busy_d = ~rdy_d;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      // Reset is the hold entry for POR: the first rst=0 cycle is already the first
      // hold cycle, so the counter is preloaded here.
      state_q      <= StHold;
      cnt_q        <= HoldLoad;
      rem_q        <= '1;
      unit_rst_l_q <= '0;
      done_q       <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      unit_rst_l_q <= unit_rst_l_d;
      done_q       <= done_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign sreq_rdy   = rdy_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign unit_rst_l = unit_rst_l_q;

endmodule
